sync_fifo_prog: RTL and testbench

//   Single-clock FIFO, parametrised in width, depth and read mode.

---
 rtl/sync_fifo_prog_if.sv | 29 ++
 rtl/sync_fifo_prog.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for the single-clock programmable FIFO.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  clr;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags, synchronous flush and selectable registered/FWFT read.
module sync_fifo_prog #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input logic            wclk,
    input logic            wrst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] ONE_L    = PW'(1);
    localparam logic [PW-1:0] ZERO_L   = PW'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] rbin_r;
    logic [PW-1:0] count_r;
    logic          wfull_r;
    logic          rempty_r;
    logic          afull_r;
    logic          aempty_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          wr_fire_s;
    logic          rd_fire_s;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] rbin_next_s;
    logic [PW-1:0] count_next_s;
    logic          wfull_next_s;
    logic          rempty_next_s;
    logic          afull_next_s;
    logic          aempty_next_s;

    // Fire decisions use only registered flags; flags are derived from the post-edge occupancy.
    always_comb begin
        wr_fire_s     = 1'b0;
        rd_fire_s     = 1'b0;
        wbin_next_s   = wbin_r;
        rbin_next_s   = rbin_r;
        wr_fire_s     = bus.winc & ~wfull_r;
        rd_fire_s     = bus.rinc & ~rempty_r;
        if (wr_fire_s) begin
            wbin_next_s = wbin_r + ONE_L;
        end else begin
            wbin_next_s = wbin_r;
        end
        if (rd_fire_s) begin
            rbin_next_s = rbin_r + ONE_L;
        end else begin
            rbin_next_s = rbin_r;
        end
        count_next_s  = wbin_next_s - rbin_next_s;
        wfull_next_s  = (count_next_s == DEPTH_L);
        rempty_next_s = (count_next_s == ZERO_L);
        afull_next_s  = (count_next_s >= AFULL_L);
        aempty_next_s = (count_next_s <= AEMPTY_L);
    end

    // Pointer, occupancy and flag registers; flush mirrors reset except for read data.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_r      <= ZERO_L;
            rbin_r      <= ZERO_L;
            count_r     <= ZERO_L;
            wfull_r     <= 1'b0;
            rempty_r    <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clr) begin
            wbin_r      <= ZERO_L;
            rbin_r      <= ZERO_L;
            count_r     <= ZERO_L;
            wfull_r     <= 1'b0;
            rempty_r    <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wbin_r      <= wbin_next_s;
            rbin_r      <= rbin_next_s;
            count_r     <= count_next_s;
            wfull_r     <= wfull_next_s;
            rempty_r    <= rempty_next_s;
            afull_r     <= afull_next_s;
            aempty_r    <= aempty_next_s;
            overflow_r  <= overflow_r | (bus.winc & wfull_r);
            underflow_r <= underflow_r | (bus.rinc & rempty_r);
        end
    end

    // Storage array; contents deliberately survive reset and flush.
    always_ff @(posedge wclk) begin
        if (wr_fire_s && !bus.clr) begin
            mem_r[wbin_r[ADDR_WIDTH-1:0]] <= bus.wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_r;

            // Registered read port: loads only on an accepted pop, otherwise holds.
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) begin
                    rdata_r <= {DATA_WIDTH{1'b0}};
                end else if (!bus.clr && rd_fire_s) begin
                    rdata_r <= mem_r[rbin_r[ADDR_WIDTH-1:0]];
                end else begin
                    rdata_r <= rdata_r;
                end
            end

            assign bus.rdata = rdata_r;
        end else begin : g_fwft_read
            // Head word is shown directly; meaningful only while rempty is low.
            assign bus.rdata = mem_r[rbin_r[ADDR_WIDTH-1:0]];
        end
    endgenerate

    assign bus.wfull        = wfull_r;
    assign bus.rempty       = rempty_r;
    assign bus.almost_full  = afull_r;
    assign bus.almost_empty = aempty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: a registered-read and an FWFT instance receive identical stimulus and are
// checked against a queue-based occupancy model.
module tb_sync_fifo_prog;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       winc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rinc = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
    sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

    assign if0.clr = clr;  assign if0.winc = winc;  assign if0.wdata = wdata;  assign if0.rinc = rinc;
    assign if1.clr = clr;  assign if1.winc = winc;  assign if1.wdata = wdata;  assign if1.rinc = rinc;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0))
        dut0 (.wclk(clk), .wrst_n(rst_n), .bus(if0.slave));
    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1))
        dut1 (.wclk(clk), .wrst_n(rst_n), .bus(if1.slave));

    typedef struct {
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
        logic [7:0] rd0;
        logic       fv;
        logic [7:0] fd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [4:0] c, input logic f, input logic e,
                             input logic af, input logic ae, input logic ov, input logic un,
                             input exp_t x);
        chk({tag, ".count"}, 32'(c), 32'(x.cnt));
        chk({tag, ".wfull"}, 32'(f), 32'(x.full));
        chk({tag, ".rempty"}, 32'(e), 32'(x.empty));
        chk({tag, ".almost_full"}, 32'(af), 32'(x.af));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(x.ae));
        chk({tag, ".overflow"}, 32'(ov), 32'(x.ov));
        chk({tag, ".underflow"}, 32'(un), 32'(x.un));
    endtask

    // Monitor: after every active edge compare both instances against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk_flags("reg", if0.count, if0.wfull, if0.rempty, if0.almost_full,
                          if0.almost_empty, if0.overflow, if0.underflow, x);
                chk_flags("fwft", if1.count, if1.wfull, if1.rempty, if1.almost_full,
                          if1.almost_empty, if1.overflow, if1.underflow, x);
                chk("reg.rdata", 32'(if0.rdata), 32'(x.rd0));
                if (x.fv) chk("fwft.rdata", 32'(if1.rdata), 32'(x.fd));
            end
        end
    end

    // Apply one cycle of stimulus and predict the state after the coming edge.
    task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
        exp_t x;
        logic full_m, empty_m;
        @(negedge clk);
        clr = c; winc = w; wdata = d; rinc = r;
        if (c) begin
            model_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            full_m  = (model_q.size() == 16);
            empty_m = (model_q.size() == 0);
            if (w && full_m)  m_ov = 1'b1;
            if (r && empty_m) m_un = 1'b1;
            if (r && !empty_m) m_rd0 = model_q.pop_front();
            if (w && !full_m) model_q.push_back(d);
        end
        x.cnt   = model_q.size();
        x.full  = (model_q.size() == 16);
        x.empty = (model_q.size() == 0);
        x.af    = (model_q.size() >= 14);
        x.ae    = (model_q.size() <= 2);
        x.ov    = m_ov;
        x.un    = m_un;
        x.rd0   = m_rd0;
        x.fv    = (model_q.size() > 0);
        x.fd    = (model_q.size() > 0) ? model_q[0] : 8'h00;
        exp_q.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".count"}, 32'(if0.count), 32'd0);
        chk({tag, ".rempty"}, 32'(if0.rempty), 32'd1);
        chk({tag, ".wfull"}, 32'(if0.wfull), 32'd0);
        chk({tag, ".almost_empty"}, 32'(if0.almost_empty), 32'd1);
        chk({tag, ".almost_full"}, 32'(if0.almost_full), 32'd0);
        chk({tag, ".overflow"}, 32'(if0.overflow), 32'd0);
        chk({tag, ".underflow"}, 32'(if0.underflow), 32'd0);
        chk({tag, ".rdata"}, 32'(if0.rdata), 32'd0);
        chk({tag, ".fwft_count"}, 32'(if1.count), 32'd0);
        chk({tag, ".fwft_rempty"}, 32'(if1.rempty), 32'd1);
    endtask

    // Stimulus sequence covering fill, drain, wrap, FWFT, flush and async reset.
    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45));
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_q.delete();
        m_ov  = 1'b0;
        m_un  = 1'b0;
        m_rd0 = 8'h00;
        winc  = 1'b0;
        rinc  = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            step(1'b0, ($urandom_range(0, 99) < 50), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 50));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
